// File: rtl/mpi_master.sv
// mpi_master: host-port to 1801VM1 MPI bus initiator.
// Runs word-read, word-write and byte-write bus cycles. Each cycle ends with
// a one-cycle ack. err qualifies ack on a reply timeout or an odd word address.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req, we, bsel         request (taken only in idle), write, byte-write select
//   addr, wdata           byte address, write data (byte write uses wdata[7:0])
//   ack, err, busy        transfer end pulse, error qualifier, busy flag
//   rdata                 read data, held until the next successful read
//   ad_n                  inverted multiplexed address/data bus (Z when released)
//   sel_n                 fixed 2'b11 (external memory space)
//   sync_n, din_n, dout_n, wtbt_n   active-low bus strobes
//   rply_n                active-low responder reply
module mpi_master #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        bsel,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    inout  wire  [15:0] ad_n,
    output logic [1:0]  sel_n,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    input  logic        rply_n
);

    localparam logic [7:0] TmoCnt = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StAddr, StSync, StTurn, StStrb, StRel, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        we_q, we_d, bsel_q, bsel_d, fail_q, fail_d;
    logic [7:0]  cnt_q, cnt_d;

    // Bus and host outputs are computed from the next state and registered.
    logic [15:0] ad_out_q, ad_out_d;
    logic        ad_oe_q, ad_oe_d;
    logic        sync_n_q, sync_n_d, din_n_q, din_n_d, dout_n_q, dout_n_d;
    logic        wtbt_n_q, wtbt_n_d;
    logic        ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic        addr_ph, strb;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        bsel_d  = bsel_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    bsel_d  = bsel;
                    // Only byte writes may target an odd address.
                    if (addr[0] && !(we && bsel)) begin
                        fail_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        fail_d  = 1'b0;
                        state_d = StAddr;
                    end
                end
            end
            StAddr: state_d = StSync;
            StSync: state_d = we_q ? StStrb : StTurn;
            StTurn: state_d = StStrb;
            StStrb: begin
                if (!rply_n) begin
                    if (!we_q) rdata_d = ~ad_n;
                    state_d = StRel;
                end else if (cnt_q == TmoCnt) begin
                    fail_d  = 1'b1;
                    state_d = StRel;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // After a timeout the responder is absent, so do not wait for rply_n.
            StRel: if (fail_q || rply_n) state_d = StDone;
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase

        addr_ph  = (state_d == StAddr) || (state_d == StSync);
        strb     = (state_d == StStrb);
        sync_n_d = !((state_d == StSync) || (state_d == StTurn) ||
                     (state_d == StStrb) || (state_d == StRel));
        din_n_d  = !(strb && !we_d);
        dout_n_d = !(strb && we_d);
        ad_oe_d  = addr_ph || (strb && we_d);
        if (addr_ph) begin
            ad_out_d = ~addr_d;
        end else if (bsel_d) begin
            ad_out_d = ~{wdata_d[7:0], wdata_d[7:0]};
        end else begin
            ad_out_d = ~wdata_d;
        end
        if (addr_ph) begin
            wtbt_n_d = ~we_d;
        end else if (strb && we_d) begin
            wtbt_n_d = ~bsel_d;
        end else begin
            wtbt_n_d = 1'b1;
        end
        ack_d  = (state_d == StDone);
        err_d  = (state_d == StDone) && fail_d;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            bsel_q   <= 1'b0;
            fail_q   <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            sync_n_q <= 1'b1;
            din_n_q  <= 1'b1;
            dout_n_q <= 1'b1;
            wtbt_n_q <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            bsel_q   <= bsel_d;
            fail_q   <= fail_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            sync_n_q <= sync_n_d;
            din_n_q  <= din_n_d;
            dout_n_q <= dout_n_d;
            wtbt_n_q <= wtbt_n_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign ad_n   = ad_oe_q ? ad_out_q : 16'hzzzz;
    assign sel_n  = 2'b11;
    assign sync_n = sync_n_q;
    assign din_n  = din_n_q;
    assign dout_n = dout_n_q;
    assign wtbt_n = wtbt_n_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mpi_master.sv
// tb_mpi_master: scoreboard bench for mpi_master with a behavioural RAM responder
// (zero-wait or early-reply), mapped at byte addresses 0x0000..0x0FFF.
module tb_mpi_master;

    localparam int unsigned Tmo = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, bsel = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic        ack, err, busy;
    logic [15:0] rdata;
    wire  [15:0] ad_n;
    logic [1:0]  sel_n;
    logic        sync_n, din_n, dout_n, wtbt_n;
    logic        rply_n;

    mpi_master #(.TIMEOUT(Tmo)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .bsel(bsel), .addr(addr),
        .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy), .ad_n(ad_n),
        .sel_n(sel_n), .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n),
        .wtbt_n(wtbt_n), .rply_n(rply_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- responder ----------------
    logic [15:0] mem [0:2047];
    logic [15:0] lat_addr = '0;
    logic        early = 1'b0;
    logic        served = 1'b0;
    logic        sel_hit;
    logic        strobe;
    int          sync_falls = 0;

    always @(negedge sync_n) begin
        lat_addr = ~ad_n;
        sync_falls++;
    end

    assign sel_hit = (lat_addr < 16'h1000) && (sel_n == 2'b11);
    assign strobe  = !din_n || !dout_n;
    // Driven high when idle, standing in for the external pull-up.
    assign rply_n  = !(!sync_n && sel_hit && (early ? !served : strobe));
    assign ad_n    = (!sync_n && sel_hit && !din_n) ? ~mem[lat_addr[11:1]] : 16'hzzzz;

    always @(posedge clk) begin
        if (sync_n) served <= 1'b0;
        else if (strobe && !rply_n) served <= 1'b1;
        if (!sync_n && sel_hit && !dout_n && !rply_n) begin
            if (!wtbt_n) begin
                if (lat_addr[0]) mem[lat_addr[11:1]][15:8] <= ~ad_n[15:8];
                else mem[lat_addr[11:1]][7:0] <= ~ad_n[7:0];
            end else begin
                mem[lat_addr[11:1]] <= ~ad_n;
            end
        end
    end

    // ---------------- strobe observer ----------------
    int          strb_len = 0;
    int          strb_start = 0;
    logic        in_strb = 1'b0;
    logic        strb_wtbt = 1'b1;
    logic [15:0] strb_ad = '0;

    always @(negedge clk) begin
        if (strobe) begin
            if (!in_strb) begin
                strb_start = cyc;
                strb_len = 0;
            end
            strb_len++;
            strb_wtbt = wtbt_n;
            strb_ad = ad_n;
            in_strb = 1'b1;
        end else begin
            in_strb = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          c0;
        int          lat;
        logic        err;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];
    int   ack_cyc = 0;

    always @(negedge clk) begin
        if (ack) begin
            ack_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 32'(cyc - e.c0 + 1), 32'(e.lat));
                chk("err", 32'(err), 32'(e.err));
                chk("rdata", 32'(rdata), 32'(e.rdata));
                chk("busy_at_ack", 32'(busy), 32'd1);
                chk("sync_n_at_ack", 32'(sync_n), 32'd1);
            end
        end
    end

    task automatic issue(input logic w, input logic b, input logic [15:0] a,
                         input logic [15:0] d, output int c0);
        @(negedge clk);
        req = 1'b1; we = w; bsel = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
        c0 = cyc;
        req = 1'b0;
    endtask

    task automatic xfer(input logic w, input logic b, input logic [15:0] a,
                        input logic [15:0] d, input int lat, input logic e,
                        input logic [15:0] rd);
        int   c0;
        bit   seen;
        exp_t x;
        issue(w, b, a, d, c0);
        x.c0 = c0; x.lat = lat; x.err = e; x.rdata = rd;
        sb.push_back(x);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_wait: got no ack expected ack within 300 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        int falls0;
        int c0;
        bit hit;

        // Reset state
        #12;
        chk("rst_sync_n", 32'(sync_n), 32'd1);
        chk("rst_din_n", 32'(din_n), 32'd1);
        chk("rst_dout_n", 32'(dout_n), 32'd1);
        chk("rst_wtbt_n", 32'(wtbt_n), 32'd1);
        chk("rst_ack_err_busy", 32'({ack, err, busy}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sel_n", 32'(sel_n), 32'h3);

        // Word write then read, zero-wait responder
        xfer(1'b1, 1'b0, 16'h0100, 16'h1234, 5, 1'b0, 16'h0000);
        xfer(1'b0, 1'b0, 16'h0100, 16'h0000, 6, 1'b0, 16'h1234);

        // Byte write to the odd byte; upper wdata byte must be ignored
        xfer(1'b1, 1'b1, 16'h0101, 16'h55AB, 5, 1'b0, 16'h1234);
        chk("byte_wtbt_n", 32'(strb_wtbt), 32'd0);
        chk("byte_ad_n", 32'(strb_ad), 32'h5454);
        xfer(1'b0, 1'b0, 16'h0100, 16'h0000, 6, 1'b0, 16'hAB34);

        // Early-reply responder read
        xfer(1'b1, 1'b0, 16'h0200, 16'hBEEF, 5, 1'b0, 16'hAB34);
        early = 1'b1;
        xfer(1'b0, 1'b0, 16'h0200, 16'h0000, 6, 1'b0, 16'hBEEF);
        early = 1'b0;
        chk("early_strobe_len", 32'(strb_len), 32'd1);

        // Unmapped address: timeout, rdata unchanged
        xfer(1'b0, 1'b0, 16'h8000, 16'h0000, 14, 1'b1, 16'hBEEF);
        chk("tmo_from_strb", 32'(ack_cyc - strb_start + 1), 32'(Tmo + 3));
        chk("tmo_sync_n_after", 32'(sync_n), 32'd1);

        // Odd word accesses: immediate error, no bus cycle
        falls0 = sync_falls;
        xfer(1'b0, 1'b0, 16'h0003, 16'h0000, 1, 1'b1, 16'hBEEF);
        xfer(1'b1, 1'b0, 16'h0005, 16'h1111, 1, 1'b1, 16'hBEEF);
        chk("odd_no_sync", 32'(sync_falls - falls0), 32'd0);

        // Reset while strobing: bus released at once, no ack
        issue(1'b0, 1'b0, 16'h8000, 16'h0000, c0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (!din_n) hit = 1'b1;
        end
        chk("reached_strb", 32'(hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sync_n", 32'(sync_n), 32'd1);
        chk("arst_strobes", 32'({din_n, dout_n}), 32'h3);
        chk("arst_busy_ack", 32'({busy, ack}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 1'b0, 16'h0100, 16'h0000, 6, 1'b0, 16'hAB34);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
